// File: rtl/led_mode_ctrl.sv
// LED mode controller: each press event steps OFF -> ON -> BLINK -> BREATH -> OFF.
// The LED output is active-low and registered one stage after the mode register.
module led_mode_ctrl #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2,
  parameter int PWM_BITS = 8,
  parameter int STEP_CYC = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       evt,
  output logic [1:0] mode_o,
  output logic       led
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SW   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  localparam logic [BW-1:0]       BLINK_LAST = BW'(HALF - 1);
  localparam logic [SW-1:0]       STEP_LAST  = SW'(STEP_CYC - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
  localparam logic [PWM_BITS-1:0] DUTY_MIN   = '0;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_ON     = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_BREATH = 2'd3;

  logic [1:0]          mode;
  logic [BW-1:0]       blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [SW-1:0]       step_cnt;
  logic                dir_up;
  logic                led_next;

  assign mode_o = mode;

  // LED level derived only from registered state, so evt never reaches led combinationally.
  always_comb begin
    led_next = 1'b1;
    case (mode)
      MODE_OFF:    led_next = 1'b1;
      MODE_ON:     led_next = 1'b0;
      MODE_BLINK:  led_next = blink_phase;
      MODE_BREATH: led_next = !(pwm_cnt < duty);
      default:     led_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= MODE_OFF;
      led         <= 1'b1;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      pwm_cnt     <= '0;
      duty        <= '0;
      step_cnt    <= '0;
      dir_up      <= 1'b1;
    end else begin
      led <= led_next;
      if (evt) begin
        mode        <= mode + 2'd1;
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        pwm_cnt     <= '0;
        duty        <= '0;
        step_cnt    <= '0;
        dir_up      <= 1'b1;
      end else begin
        // Counters not owned by the current mode stay parked at zero.
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
        pwm_cnt     <= '0;
        duty        <= '0;
        step_cnt    <= '0;
        dir_up      <= 1'b1;
        case (mode)
          MODE_BLINK: begin
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt   <= '0;
              blink_phase <= !blink_phase;
            end else begin
              blink_cnt   <= blink_cnt + 1'b1;
              blink_phase <= blink_phase;
            end
          end
          MODE_BREATH: begin
            pwm_cnt <= pwm_cnt + 1'b1;
            duty    <= duty;
            dir_up  <= dir_up;
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              // At an endpoint the step only flips direction, holding duty one extra step.
              if (dir_up) begin
                if (duty == DUTY_MAX) dir_up <= 1'b0;
                else                  duty   <= duty + 1'b1;
              end else begin
                if (duty == DUTY_MIN) dir_up <= 1'b1;
                else                  duty   <= duty - 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: a time-since-entry model checked every cycle,
// plus directed literal expectations for reset, mode wrap, blink and breath.
module tb_led_mode_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int BLINK_HZ = 100;
  localparam int PWM_BITS = 3;
  localparam int STEP_CYC = 4;
  localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);
  localparam int PWM_M    = 1 << PWM_BITS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       evt;
  logic [1:0] mode_o;
  logic       led;

  int checks   = 0;
  int failures = 0;

  // Model state: current mode and number of clock edges spent in it.
  int   m_mode = 0;
  int   m_t    = 0;
  logic m_led  = 1'b1;

  led_mode_ctrl #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_HZ(BLINK_HZ),
    .PWM_BITS(PWM_BITS),
    .STEP_CYC(STEP_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .evt   (evt),
    .mode_o(mode_o),
    .led   (led)
  );

  always #5 clk = ~clk;

  // Expected LED for a given mode after t edges in that mode.
  function automatic logic led_of(input int md, input int t);
    int pwm, k, km, d;
    case (md)
      0: return 1'b1;
      1: return 1'b0;
      2: return ((t / HALF) % 2) != 0;
      default: begin
        pwm = t % PWM_M;
        k   = t / STEP_CYC;
        km  = k % (2 * PWM_M);
        d   = (km < PWM_M) ? km : (2 * PWM_M - 1 - km);
        return !(pwm < d);
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_t    = 0;
      m_led  = 1'b1;
    end else begin
      m_led = led_of(m_mode, m_t);
      if (evt) begin
        m_mode = (m_mode + 1) % 4;
        m_t    = 0;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive evt for n edges starting now (at a falling edge), then drop it.
  task automatic applyStimulus(input logic e, input int n);
    evt = e;
    repeat (n) @(negedge clk);
    evt = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("mode_vs_model", {30'd0, mode_o}, m_mode);
    checkOutput("led_vs_model", {31'd0, led}, {31'd0, m_led});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wrap_exp [3] = '{2, 3, 0};
    logic [14:0] blink_pat;
    int lit_exp [18] = '{0, 0, 2, 0, 4, 1, 4, 3, 4, 2, 4, 0, 3, 0, 1, 0, 0, 0};
    int cnt;

    blink_pat = 15'b000001111100000;
    rst_n = 1'b0;
    evt   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_mode", {30'd0, mode_o}, 0);
    checkOutput("reset_led", {31'd0, led}, 1);
    rst_n = 1'b1;

    $display("[TB] reset and first press");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1);
      checkOutput("idle_mode", {30'd0, mode_o}, 0);
      checkOutput("idle_led", {31'd0, led}, 1);
    end
    applyStimulus(1'b1, 1);
    checkOutput("press_mode_same_edge", {30'd0, mode_o}, 1);
    checkOutput("press_led_before", {31'd0, led}, 1);
    applyStimulus(1'b0, 1);
    checkOutput("press_led_next_edge", {31'd0, led}, 0);

    $display("[TB] mode wrap");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 19);
      applyStimulus(1'b1, 1);
      checkOutput($sformatf("wrap_step%0d", i), {30'd0, mode_o}, wrap_exp[i]);
    end
    applyStimulus(1'b0, 1);
    checkOutput("wrap_led_off", {31'd0, led}, 1);
    applyStimulus(1'b1, 3);
    checkOutput("held_evt_3", {30'd0, mode_o}, 3);
    applyStimulus(1'b0, 5);

    $display("[TB] blink");
    applyStimulus(1'b1, 3);
    checkOutput("blink_enter", {30'd0, mode_o}, 2);
    for (int j = 1; j <= 15; j++) begin
      applyStimulus(1'b0, 1);
      checkOutput($sformatf("blink_pat%0d", j), {31'd0, led}, {31'd0, blink_pat[15 - j]});
    end
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 1);
    checkOutput("evt_at_toggle_mode", {30'd0, mode_o}, 3);
    checkOutput("evt_at_toggle_led", {31'd0, led}, 1);

    $display("[TB] breath");
    for (int k = 0; k < 18; k++) begin
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b0, 1);
        if (led == 1'b0) cnt++;
      end
      checkOutput($sformatf("breath_lit_step%0d", k), cnt, lit_exp[k]);
    end

    $display("[TB] reset mid-breath");
    applyStimulus(1'b0, 13);
    checkOutput("pre_reset_mode", {30'd0, mode_o}, 3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_mode", {30'd0, mode_o}, 0);
    checkOutput("async_reset_led", {31'd0, led}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1);
      checkOutput("post_reset_mode", {30'd0, mode_o}, 0);
      checkOutput("post_reset_led", {31'd0, led}, 1);
    end
    applyStimulus(1'b1, 1);
    checkOutput("post_reset_press", {30'd0, mode_o}, 1);
    applyStimulus(1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
